alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter WIDTH, default 32, data width of logic-unit results.
REQ-002 Parameter REGW, default 5, width of destination-register tag.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  stage can accept a beat this cycle.
REQ-007 in_op  input  2  logic op select: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 in_and / in_or / in_xor  input  WIDTH each  parallel outputs of the AND, OR, XOR 32-bit units.
REQ-009 in_rd  input  REGW  destination register tag.
REQ-010 out_valid  output  1  result beat present to writeback.
REQ-011 out_ready  input  1  writeback accepts beat.
REQ-012 out_result  output  WIDTH  selected result.
REQ-013 out_rd  output  REGW  tag travelling with result.
REQ-014 out_zero / out_neg  output  1 each  result==0 / result[WIDTH-1].

Function
REQ-015 Selection SHALL be: 00->in_and, 01->in_or, 10->in_xor, 11->bitwise NOT of in_or.
REQ-016 Flags SHALL be computed from the selected result at capture time and stored with it.
REQ-017 Stage SHALL be a 2-entry in-order buffer with states EMPTY, ONE, FULL (count 0/1/2).
REQ-018 Push SHALL occur when in_valid && in_ready; pop when out_valid && out_ready.
REQ-019 in_ready SHALL be registered: high in EMPTY and ONE, low in FULL.
REQ-020 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE; FULL+pop->ONE; otherwise hold.
REQ-021 Latency SHALL be one cycle: beat pushed at edge N is on outputs with out_valid high after edge N.
REQ-022 out_valid SHALL equal (count != 0); out_* SHALL present the oldest entry.
REQ-023 While out_valid && !out_ready, out_result, out_rd, out_zero, out_neg SHALL remain stable.
REQ-024 Ordering SHALL be strict FIFO; no beat dropped or duplicated under any valid/ready pattern.
REQ-025 Inputs SHALL be ignored when in_ready is low, regardless of in_valid.
REQ-026 Payload registers SHALL not change when no push/pop occurs.

Reset
REQ-027 While reset is high at a clock edge: count->0 (EMPTY), out_valid 0, out_result 0, out_rd 0, out_zero 0, out_neg 0, in_ready 0.
REQ-028 in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-029 Reset mid-operation SHALL discard all buffered entries; no partial beat emitted afterwards.

Structure
REQ-030 Op encodings (OP_AND, OP_OR, OP_XOR, OP_NOR) and default WIDTH/REGW SHALL live in shared package alu_pkg.
REQ-031 Selection plus flag generation SHALL be one combinational sub-module, alu_logic_sel; buffer and state machine stay in alu_result_stage.

Verification
REQ-032 in_op=01, in_or=0x0000_F0F0, out_ready=1 -> next cycle out_result=0x0000_F0F0, out_zero=0, out_neg=0, out_valid=1 for one cycle.
REQ-033 in_op=11, in_or=0xFFFF_FFFF -> out_result=0x0000_0000, out_zero=1; in_or=0x0000_0000 -> out_result=0xFFFF_FFFF, out_neg=1.
REQ-034 out_ready=0, push rd=1 then rd=2 -> in_ready low after second push, third beat ignored; out_ready=1 -> rd=1 then rd=2 on consecutive cycles, values held while stalled.
REQ-035 Simultaneous push+pop in ONE for 8 cycles, rd=1..8 -> count stays ONE, out_rd sequence 1..8, one-cycle lag.
REQ-036 Reset asserted while FULL -> next cycle out_valid=0, outputs 0, in_ready=0; after release in_ready=1, no stale beat emitted.
REQ-037 Random valid/ready, 10k beats vs. reference queue -> zero mismatches, zero loss.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: logic-op encodings, default
// widths and the result-buffer occupancy states.
package alu_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_REGW  = 5;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } alu_op_e;

  // Encoding equals the number of buffered entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_logic_sel.sv
// Picks one of the parallel logic-unit results and derives its zero and
// negative flags. Purely combinational.
module alu_logic_sel
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] and_res,
  input  logic [WIDTH-1:0] or_res,
  input  logic [WIDTH-1:0] xor_res,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg
);

  always_comb begin
    result = and_res;
    case (alu_op_e'(op))
      OP_AND:  result = and_res;
      OP_OR:   result = or_res;
      OP_XOR:  result = xor_res;
      OP_NOR:  result = ~or_res;
      default: result = and_res;
    endcase
  end

  assign zero = (result == '0);
  assign neg  = result[WIDTH-1];

endmodule

// File: rtl/alu_result_stage.sv
// Two-entry in-order result buffer between the logic units and writeback.
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; in_ready is registered and out_valid reflects a non-empty buffer.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REGW  = DEF_REGW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_and,
  input  logic [WIDTH-1:0] in_or,
  input  logic [WIDTH-1:0] in_xor,
  input  logic [REGW-1:0]  in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [REGW-1:0]  out_rd,
  output logic             out_zero,
  output logic             out_neg,
  output logic [1:0]       dbg_state
);

  buf_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] res_q  [0:1];
  logic [WIDTH-1:0] res_d  [0:1];
  logic [REGW-1:0]  rd_q   [0:1];
  logic [REGW-1:0]  rd_d   [0:1];
  logic             zero_q [0:1];
  logic             zero_d [0:1];
  logic             neg_q  [0:1];
  logic             neg_d  [0:1];

  logic [WIDTH-1:0] sel_result;
  logic             sel_zero;
  logic             sel_neg;
  logic             push;
  logic             pop;

  alu_logic_sel #(.WIDTH(WIDTH)) u_sel (
    .op      (in_op),
    .and_res (in_and),
    .or_res  (in_or),
    .xor_res (in_xor),
    .result  (sel_result),
    .zero    (sel_zero),
    .neg     (sel_neg)
  );

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    res_d    = res_q;
    rd_d     = rd_q;
    zero_d   = zero_q;
    neg_d    = neg_q;

    // Flags are frozen with the result so writeback sees them consistent.
    if (push) begin
      res_d[wr_ptr_q]  = sel_result;
      rd_d[wr_ptr_q]   = in_rd;
      zero_d[wr_ptr_q] = sel_zero;
      neg_d[wr_ptr_q]  = sel_neg;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case (state_q)
      ST_EMPTY: if (push) state_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_d = ST_FULL;
        else if (pop && !push) state_d = ST_EMPTY;
      end
      ST_FULL:  if (pop) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase

    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        res_q[i]  <= '0;
        rd_q[i]   <= '0;
        zero_q[i] <= 1'b0;
        neg_q[i]  <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      res_q      <= res_d;
      rd_q       <= rd_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != ST_EMPTY);
  assign out_result = res_q[rd_ptr_q];
  assign out_rd     = rd_q[rd_ptr_q];
  assign out_zero   = zero_q[rd_ptr_q];
  assign out_neg    = neg_q[rd_ptr_q];
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: op-select vector table, stall/streaming/reset
// sequences, and a randomised handshake run against a reference queue.
module tb_alu_result_stage;

  localparam int W  = 32;
  localparam int RW = 5;
  localparam int EW = W + RW + 2;
  localparam int NB = 10000;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_and, in_or, in_xor;
  logic [RW-1:0] in_rd;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [RW-1:0] out_rd;
  logic          out_zero, out_neg;
  logic [1:0]    dbg_state;
  logic [EW-1:0] out_pack;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  alu_result_stage #(.WIDTH(W), .REGW(RW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_and     (in_and),
    .in_or      (in_or),
    .in_xor     (in_xor),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  assign out_pack = {out_result, out_rd, out_zero, out_neg};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] o, input logic [W-1:0] x, input logic [RW-1:0] rd);
    in_valid = v;
    in_op    = op;
    in_and   = a;
    in_or    = o;
    in_xor   = x;
    in_rd    = rd;
  endtask

  function automatic logic [EW-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] o, input logic [W-1:0] x,
                                          input logic [RW-1:0] rd);
    logic [W-1:0] r;
    case (op)
      2'b00:   r = a;
      2'b01:   r = o;
      2'b10:   r = x;
      default: r = ~o;
    endcase
    return {r, rd, (r == '0), r[W-1]};
  endfunction

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a, o, x;
    logic [RW-1:0] rd;
    logic [W-1:0]  exp_res;
    logic          exp_zero, exp_neg;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [EW-1:0] held_val;
    logic          held;
    int            sent, got, cyc;

    vt[0] = '{2'b01, 32'h1234_5678, 32'h0000_F0F0, 32'hAAAA_0000, 5'd3,  32'h0000_F0F0, 1'b0, 1'b0};
    vt[1] = '{2'b11, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4,  32'h0000_0000, 1'b1, 1'b0};
    vt[2] = '{2'b11, 32'h0000_0003, 32'h0000_0000, 32'h0000_0004, 5'd5,  32'hFFFF_FFFF, 1'b0, 1'b1};
    vt[3] = '{2'b00, 32'h8000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 5'd6,  32'h8000_0001, 1'b0, 1'b1};
    vt[4] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 5'd7,  32'h0000_0000, 1'b1, 1'b0};
    vt[5] = '{2'b10, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_0000, 5'd31, 32'h7FFF_0000, 1'b0, 1'b0};
    vt[6] = '{2'b00, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0};
    vt[7] = '{2'b01, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 5'd17, 32'h8000_0000, 1'b0, 1'b1};

    // Reset block
    reset = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, '0, '0, '0, '0);
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_neg", out_neg, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // Single OR beat: valid for exactly one cycle
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 32'h0, 32'h0000_F0F0, 32'h0, 5'd9);
    step();
    drive(1'b0, 2'b00, '0, '0, '0, '0);
    chk("one_beat_valid", out_valid, 1);
    chk("one_beat_result", out_result, 32'h0000_F0F0);
    chk("one_beat_zero", out_zero, 0);
    chk("one_beat_neg", out_neg, 0);
    chk("one_beat_rd", out_rd, 9);
    step();
    chk("one_beat_gone", out_valid, 0);

    // Vector table, streamed back-to-back with writeback always ready
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vt[i].op, vt[i].a, vt[i].o, vt[i].x, vt[i].rd);
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_result", i), out_result, vt[i].exp_res);
      chk($sformatf("vec%0d_zero", i), out_zero, vt[i].exp_zero);
      chk($sformatf("vec%0d_neg", i), out_neg, vt[i].exp_neg);
      chk($sformatf("vec%0d_rd", i), out_rd, vt[i].rd);
    end
    drive(1'b0, 2'b00, '0, '0, '0, '0);
    step();
    chk("vec_drain", out_valid, 0);

    // Stall: fill, third beat refused, drain in order
    out_ready = 1'b0;
    drive(1'b1, 2'b01, '0, 32'h11, '0, 5'd1);
    step();
    chk("stall_rd1_rd", out_rd, 1);
    chk("stall_rd1_ready", in_ready, 1);
    drive(1'b1, 2'b01, '0, 32'h22, '0, 5'd2);
    step();
    chk("stall_full_ready", in_ready, 0);
    chk("stall_full_state", dbg_state, 2);
    drive(1'b1, 2'b01, '0, 32'h33, '0, 5'd3);
    step();
    step();
    chk("stall_hold_rd", out_rd, 1);
    chk("stall_hold_result", out_result, 32'h11);
    chk("stall_hold_state", dbg_state, 2);
    drive(1'b0, 2'b00, '0, '0, '0, '0);
    out_ready = 1'b1;
    step();
    chk("drain_rd2_rd", out_rd, 2);
    chk("drain_rd2_result", out_result, 32'h22);
    chk("drain_rd2_ready", in_ready, 1);
    step();
    chk("drain_empty", out_valid, 0);

    // Simultaneous push and pop while holding one entry
    drive(1'b1, 2'b00, 32'h100, '0, '0, 5'd1);
    step();
    chk("pp_rd1", out_rd, 1);
    for (int k = 2; k <= 8; k++) begin
      drive(1'b1, 2'b00, 32'h100 + k, '0, '0, RW'(k));
      step();
      chk($sformatf("pp_rd%0d", k), out_rd, k);
      chk($sformatf("pp_state%0d", k), dbg_state, 1);
    end
    drive(1'b0, 2'b00, '0, '0, '0, '0);
    step();
    chk("pp_empty", out_valid, 0);

    // Reset while full discards both entries
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'hDEAD_BEEF, '0, '0, 5'd11);
    step();
    drive(1'b1, 2'b00, 32'hCAFE_F00D, '0, '0, 5'd12);
    step();
    chk("rf_full", dbg_state, 2);
    drive(1'b0, 2'b00, '0, '0, '0, '0);
    reset = 1'b1;
    step();
    chk("rf_valid", out_valid, 0);
    chk("rf_result", out_result, 0);
    chk("rf_rd", out_rd, 0);
    chk("rf_in_ready", in_ready, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rf_release_ready", in_ready, 1);
    chk("rf_release_valid", out_valid, 0);
    step();
    step();
    chk("rf_no_stale", out_valid, 0);

    // Randomised handshake against a reference queue
    exp_q.delete();
    held = 1'b0;
    held_val = '0;
    sent = 0;
    got = 0;
    cyc = 0;
    while ((sent < NB || exp_q.size() != 0) && cyc < 60000) begin
      drive((sent < NB) && ($urandom_range(3) != 0), 2'($urandom_range(3)),
            $urandom(), $urandom(), $urandom(), RW'($urandom_range(31)));
      out_ready = ($urandom_range(3) != 0);
      chk("rand_occupancy", out_valid, (exp_q.size() != 0));
      if (held) chk("rand_hold", out_pack, held_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rand_spurious", 1, 0);
        else chk("rand_beat", out_pack, exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_op, in_and, in_or, in_xor, in_rd));
        sent++;
      end
      held = out_valid && !out_ready;
      held_val = out_pack;
      step();
      cyc++;
    end
    chk("rand_timeout", (cyc < 60000), 1);
    chk("rand_beats", got, NB);
    drive(1'b0, 2'b00, '0, '0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
